execute_arbiter: RTL and testbench

EXECUTE_ARBITER -- requirements
Module: execute_arbiter

---
 rtl/cpu_consts.sv | 34 +++
 rtl/execute_arbiter_if.sv | 11 +
 rtl/execute_arbiter_alu.sv | 42 ++++
 rtl/execute_arbiter.sv | 119 +++++++++++
 tb/tb_execute_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_consts.sv
// Shared CPU constants: ALU opcode encoding and the request record handed to
// the execute stage.
package cpu_consts;

  localparam int ALU_OP_W  = 4;
  localparam int TAG_MAX_W = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SRL  = 4'b0011,
    OP_SRA  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_AND  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLT  = 4'b1001
  } alu_op_e;

  // Tag is carried at the widest supported width; users keep their low bits.
  typedef struct packed {
    logic [63:0]          opr_a;
    logic [63:0]          opr_b;
    logic [ALU_OP_W-1:0]  alu_func;
    logic [TAG_MAX_W-1:0] tag;
  } alu_req_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/execute_arbiter_if.sv
// Link between the arbiter and the shared combinational execute unit.
interface execute_arbiter_if;
  import cpu_consts::*;

  alu_req_t    req;
  logic [63:0] result;
  logic        err;

  modport master (output req, input result, err);
  modport slave  (input req, output result, err);
endinterface

// File: rtl/execute_arbiter_alu.sv
// Combinational 64-bit ALU; unsupported opcodes yield zero with err set.
module execute_arbiter_alu
  import cpu_consts::*;
(
  execute_arbiter_if.slave bus
);

  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  shamt;
  logic [63:0] result;
  logic        err;

  assign a     = bus.req.opr_a;
  assign b     = bus.req.opr_b;
  assign shamt = b[5:0];

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (bus.req.alu_func)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_SLTU: result = {63'd0, (a < b)};
      OP_SLT:  result = {63'd0, ($signed(a) < $signed(b))};
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

  assign bus.result = result;
  assign bus.err    = err;

endmodule

// File: rtl/execute_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a single-entry
// output register that can accept a new operation while draining the old one.
module execute_arbiter
  import cpu_consts::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             resetn_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [63:0]      req0_opr_a_i,
  input  logic [63:0]      req0_opr_b_i,
  input  logic [3:0]       req0_alu_func_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [63:0]      req1_opr_a_i,
  input  logic [63:0]      req1_opr_b_i,
  input  logic [3:0]       req1_alu_func_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [63:0]      res_data_o,
  output logic             res_id_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_err_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the requester's operand fields.

  execute_arbiter_if alu_bus ();

  execute_arbiter_alu u_alu (
    .bus (alu_bus.slave)
  );

  out_state_e       state_q;
  out_state_e       state_d;
  logic             last_q;
  logic             win;
  logic             can_accept;
  logic             accept;
  logic [63:0]      res_data_q;
  logic             res_id_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_err_q;
  logic             unused_tag_hi;

  // The requester that did not win last time gets priority under contention.
  always_comb begin
    if (req0_valid_i && req1_valid_i) win = ~last_q;
    else                              win = req1_valid_i;
  end

  assign can_accept   = (state_q == S_EMPTY) || res_ready_i;
  assign req0_ready_o = resetn_i && can_accept && req0_valid_i && !win;
  assign req1_ready_o = resetn_i && can_accept && req1_valid_i && win;
  assign accept       = req0_ready_o || req1_ready_o;

  always_comb begin
    alu_bus.req = '0;
    if (win) begin
      alu_bus.req.opr_a    = req1_opr_a_i;
      alu_bus.req.opr_b    = req1_opr_b_i;
      alu_bus.req.alu_func = req1_alu_func_i;
      alu_bus.req.tag      = TAG_MAX_W'(req1_tag_i);
    end else begin
      alu_bus.req.opr_a    = req0_opr_a_i;
      alu_bus.req.opr_b    = req0_opr_b_i;
      alu_bus.req.alu_func = req0_alu_func_i;
      alu_bus.req.tag      = TAG_MAX_W'(req0_tag_i);
    end
  end

  assign unused_tag_hi = ^(alu_bus.req.tag >> TAG_W);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_EMPTY;
    else           state_q <= state_d;
  end

  // A drain and a new accept in the same cycle keep the register full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept)                     state_d = S_FULL;
      S_FULL:  if (res_ready_i && !accept)     state_d = S_EMPTY;
      default:                                 state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      last_q     <= 1'b1;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      res_tag_q  <= '0;
      res_err_q  <= 1'b0;
    end else if (accept) begin
      last_q     <= win;
      res_data_q <= alu_bus.result;
      res_id_q   <= win;
      res_tag_q  <= alu_bus.req.tag[TAG_W-1:0];
      res_err_q  <= alu_bus.err;
    end
  end

  assign res_valid_o = (state_q == S_FULL);
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;
  assign res_tag_o   = res_tag_q;
  assign res_err_o   = res_err_q;

endmodule

// File: tb/tb_execute_arbiter.sv
// Directed bench for execute_arbiter: a per-cycle vector table followed by
// hand-written back-pressure and mid-operation reset sequences.
module tb_execute_arbiter;
  import cpu_consts::*;

  localparam int TAG_W = 4;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB1 = 64'h8000_0000_0000_0000;

  logic             clk;
  logic             resetn;
  logic             req0_valid, req0_ready;
  logic [63:0]      req0_a, req0_b;
  logic [3:0]       req0_func;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [63:0]      req1_a, req1_b;
  logic [3:0]       req1_func;
  logic [TAG_W-1:0] req1_tag;
  logic             res_valid, res_ready;
  logic [63:0]      res_data;
  logic             res_id;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;

  int errors = 0;
  int checks = 0;

  execute_arbiter #(.TAG_W(TAG_W)) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .req0_valid_i    (req0_valid),
    .req0_ready_o    (req0_ready),
    .req0_opr_a_i    (req0_a),
    .req0_opr_b_i    (req0_b),
    .req0_alu_func_i (req0_func),
    .req0_tag_i      (req0_tag),
    .req1_valid_i    (req1_valid),
    .req1_ready_o    (req1_ready),
    .req1_opr_a_i    (req1_a),
    .req1_opr_b_i    (req1_b),
    .req1_alu_func_i (req1_func),
    .req1_tag_i      (req1_tag),
    .res_valid_o     (res_valid),
    .res_ready_i     (res_ready),
    .res_data_o      (res_data),
    .res_id_o        (res_id),
    .res_tag_o       (res_tag),
    .res_err_o       (res_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0; logic [3:0] f0; logic [63:0] a0; logic [63:0] b0; logic [3:0] t0;
    logic        v1; logic [3:0] f1; logic [63:0] a1; logic [63:0] b1; logic [3:0] t1;
    logic        rr;
    logic        e_rdy0; logic e_rdy1; logic e_valid; logic chk_data;
    logic [63:0] e_data; logic e_id; logic [3:0] e_tag; logic e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] t);
    req0_valid = v; req0_func = f; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] t);
    req1_valid = v; req1_func = f; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  task automatic chk_out(input string p, input logic v, input logic [63:0] d,
                         input logic id, input logic [3:0] t, input logic e);
    chk({p, " valid"}, 64'(res_valid), 64'(v));
    chk({p, " data"},  res_data, d);
    chk({p, " id"},    64'(res_id), 64'(id));
    chk({p, " tag"},   64'(res_tag), 64'(t));
    chk({p, " err"},   64'(res_err), 64'(e));
  endtask

  task automatic chk_rdy(input string p, input logic r0, input logic r1);
    chk({p, " rdy0"}, 64'(req0_ready), 64'(r0));
    chk({p, " rdy1"}, 64'(req1_ready), 64'(r1));
  endtask

  initial begin
    // v0 f0 a0 b0 t0 | v1 f1 a1 b1 t1 | rr | rdy0 rdy1 valid chk | data id tag err
    vecs[0]  = '{1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, OP_SRA,  MSB1,   64'h3F, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ALL1,   1'b1, 4'h5, 1'b0};
    vecs[1]  = '{1'b1, OP_ADD,  64'h1,  64'h2,  4'h3, 1'b1, OP_XOR,  64'hF0, 64'hFF, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3,  1'b0, 4'h3, 1'b0};
    vecs[2]  = '{1'b1, OP_ADD,  64'h1,  64'h2,  4'h3, 1'b1, OP_XOR,  64'hF0, 64'hFF, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0F, 1'b1, 4'h2, 1'b0};
    vecs[3]  = '{1'b1, OP_ADD,  64'h1,  64'h2,  4'h3, 1'b1, OP_XOR,  64'hF0, 64'hFF, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3,  1'b0, 4'h3, 1'b0};
    vecs[4]  = '{1'b1, OP_ADD,  64'h1,  64'h2,  4'h3, 1'b1, OP_XOR,  64'hF0, 64'hFF, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0F, 1'b1, 4'h2, 1'b0};
    vecs[5]  = '{1'b1, 4'hC,    64'h5,  64'h6,  4'h7, 1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0,  1'b0, 4'h7, 1'b1};
    vecs[6]  = '{1'b1, OP_SLL,  64'h1,  64'h43, 4'h1, 1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8,  1'b0, 4'h1, 1'b0};
    vecs[7]  = '{1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, OP_SRL,  MSB1,   64'd63, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1,  1'b1, 4'h4, 1'b0};
    vecs[8]  = '{1'b1, OP_SLT,  ALL1,   64'h1,  4'h0, 1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1,  1'b0, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, OP_SLTU, ALL1,   64'h1,  4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0,  1'b1, 4'hF, 1'b0};
    vecs[10] = '{1'b1, OP_SUB,  64'd10, 64'd3,  4'h8, 1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h7,  1'b0, 4'h8, 1'b0};
    vecs[11] = '{1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b1, OP_AND,  64'hF0, 64'h3C, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h30, 1'b1, 4'hA, 1'b0};
    vecs[12] = '{1'b0, 4'hD,    64'h77, 64'h99, 4'hE, 1'b0, OP_ADD,  64'h55, 64'h66, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 4'h0, 1'b0};
    vecs[13] = '{1'b1, OP_OR,   64'hF0, 64'h0F, 4'h9, 1'b0, 4'h0,    64'h0,  64'h0,  4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hFF, 1'b0, 4'h9, 1'b0};

    // ---------------- reset ----------------
    resetn    = 1'b0;
    res_ready = 1'b1;
    drive0(1'b1, OP_ADD, 64'h1, 64'h1, 4'h1);
    drive1(1'b1, OP_ADD, 64'h2, 64'h2, 4'h2);
    repeat (2) @(negedge clk);
    chk_rdy("reset", 1'b0, 1'b0);
    chk_out("reset", 1'b0, 64'h0, 1'b0, 4'h0, 1'b0);
    drive0(1'b0, 4'h0, 64'h0, 64'h0, 4'h0);
    drive1(1'b0, 4'h0, 64'h0, 64'h0, 4'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_out("idle", 1'b0, 64'h0, 1'b0, 4'h0, 1'b0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 14; i++) begin
      drive0(vecs[i].v0, vecs[i].f0, vecs[i].a0, vecs[i].b0, vecs[i].t0);
      drive1(vecs[i].v1, vecs[i].f1, vecs[i].a1, vecs[i].b1, vecs[i].t1);
      res_ready = vecs[i].rr;
      @(negedge clk);
      chk_rdy($sformatf("v%0d", i), vecs[i].e_rdy0, vecs[i].e_rdy1);
      @(posedge clk); #1;
      if (vecs[i].chk_data)
        chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_id, vecs[i].e_tag, vecs[i].e_err);
      else
        chk($sformatf("v%0d valid", i), 64'(res_valid), 64'(vecs[i].e_valid));
    end

    // ---------------- back-pressure then no-bubble accept ----------------
    drive0(1'b1, OP_ADD, 64'd100, 64'd1, 4'h1);
    drive1(1'b1, OP_SUB, 64'd50,  64'd8, 4'h6);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_rdy($sformatf("hold%0d", c), 1'b0, 1'b0);
      @(posedge clk); #1;
      chk_out($sformatf("hold%0d", c), 1'b1, 64'hFF, 1'b0, 4'h9, 1'b0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk_rdy("release", 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_out("release", 1'b1, 64'd42, 1'b1, 4'h6, 1'b0);

    // ---------------- asynchronous reset while full ----------------
    res_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 64'h0, 1'b0, 4'h0, 1'b0);
    chk_rdy("async_rst", 1'b0, 1'b0);
    @(negedge clk); #1;
    resetn = 1'b1;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_out("post_rst", 1'b1, 64'd101, 1'b0, 4'h1, 1'b0);

    drive0(1'b0, 4'h0, 64'h0, 64'h0, 4'h0);
    drive1(1'b0, 4'h0, 64'h0, 64'h0, 4'h0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain valid", 64'(res_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
